// File: rtl/jt1943_rom_arb.sv
// ROM read arbiter: round-robin sharing of one SDRAM read port among N ROM clients,
// one read in flight, with a one-entry address/data cache per client.
module jt1943_rom_arb #(
   parameter int N       = 5,
   parameter int AW      = 22,
   parameter int TIMEOUT = 63
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            downloading,
   input  logic [N-1:0]    req,
   input  logic [N*AW-1:0] addr,
   output logic [N-1:0]    data_ok,
   output logic [31:0]     dout,
   output logic            sdram_re,
   output logic [AW-1:0]   sdram_addr,
   input  logic            sdram_rdy,
   input  logic [31:0]     data_read,
   output logic            timeout_err
);
   localparam int GW = (N > 1) ? $clog2(N) : 1;
   localparam int JW = GW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t          state, state_nx;
   logic [GW-1:0]   last_gnt, gnt, pick;
   logic [TW-1:0]   timer;
   logic [N-1:0]    cache_v, elig;
   logic [AW-1:0]   cache_a [N];
   logic [31:0]     cache_d [N];
   logic [AW-1:0]   addr_a  [N];
   logic            found, hit;
   logic            do_hit, do_grant, do_issue, do_done, do_tout;

   for (genvar g = 0; g < N; g++) begin : g_addr
      assign addr_a[g] = addr[g*AW +: AW];
   end

   // A client whose data_ok is high this cycle has not yet dropped req; skip it
   // so one fetch is never acknowledged twice.
   assign elig = req & ~data_ok;

   // Round-robin scan: walk downwards so the lowest offset from last_gnt wins.
   always_comb begin
      logic [JW-1:0] j;
      logic [GW-1:0] idx;
      // NOTE: every comb output gets a default first, so no path leaves a latch behind.
      found = 1'b0;
      pick  = '0;
      j     = '0;
      idx   = '0;
      for (int k = N; k >= 1; k--) begin
         j = {1'b0, last_gnt} + JW'(k);
         if (j >= JW'(N)) j = j - JW'(N);
         idx = j[GW-1:0];
         if (elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign hit = found && cache_v[pick] && (cache_a[pick] == addr_a[pick]);

   always_comb begin
      state_nx = state;
      do_hit   = 1'b0;
      do_grant = 1'b0;
      do_issue = 1'b0;
      do_done  = 1'b0;
      do_tout  = 1'b0;
      case (state)
         IDLE: if (!downloading && found) begin
            if (hit) begin
               do_hit = 1'b1;
            end else begin
               do_grant = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            do_issue = 1'b1;
            state_nx = WAIT;
         end
         WAIT: if (sdram_rdy) begin
            do_done  = 1'b1;
            state_nx = IDLE;
         end else if (timer == TW'(TIMEOUT - 1)) begin
            do_tout  = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_ok     <= '0;
         dout        <= '0;
         sdram_re    <= 1'b0;
         sdram_addr  <= '0;
         timeout_err <= 1'b0;
         cache_v     <= '0;
         last_gnt    <= '0;
         gnt         <= '0;
         timer       <= '0;
      end else begin
         data_ok <= '0;
         if (do_hit) begin
            data_ok[pick] <= 1'b1;
            dout          <= cache_d[pick];
            last_gnt      <= pick;
         end
         if (do_grant) begin
            gnt        <= pick;
            sdram_addr <= addr_a[pick];
         end
         if (do_issue) begin
            sdram_re <= ~sdram_re;
            timer    <= '0;
         end else if (state == WAIT) begin
            timer <= timer + 1'b1;
         end
         if (do_done) begin
            dout         <= data_read;
            cache_v[gnt] <= 1'b1;
            last_gnt     <= gnt;
            if (req[gnt]) data_ok[gnt] <= 1'b1;
         end
         if (do_tout) timeout_err <= 1'b1;
         // A ROM reload makes every cached word stale; this overrides a same-cycle fill.
         if (downloading) cache_v <= '0;
      end
   end

   // NOTE: cache storage has no reset; cache_v alone decides whether an entry is usable.
   always_ff @(posedge clk) begin
      if (do_done) begin
         cache_a[gnt] <= sdram_addr;
         cache_d[gnt] <= data_read;
      end
   end

endmodule

// File: tb/tb_jt1943_rom_arb.sv
// Directed bench for jt1943_rom_arb: SDRAM responder model, data_ok monitor and an
// expected-result queue compared in order against observed acknowledgements.
module tb_jt1943_rom_arb;
   localparam int N  = 5;
   localparam int AW = 22;

   logic            clk = 1'b0;
   logic            rst, downloading, sdram_rdy, sdram_re, timeout_err;
   logic [N-1:0]    req, data_ok;
   logic [N*AW-1:0] addr;
   logic [31:0]     dout, data_read;
   logic [AW-1:0]   sdram_addr;

   jt1943_rom_arb #(.N(N), .AW(AW), .TIMEOUT(63)) dut (
      .clk(clk), .rst(rst), .downloading(downloading), .req(req), .addr(addr),
      .data_ok(data_ok), .dout(dout), .sdram_re(sdram_re), .sdram_addr(sdram_addr),
      .sdram_rdy(sdram_rdy), .data_read(data_read), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct { int idx; logic [31:0] data; } exp_t;
   typedef struct { int idx; logic [31:0] data; int cyc; bit onehot; } obs_t;

   exp_t exp_q[$];
   obs_t obs[$];
   int   rd = 0;
   int   cyc = 0;
   int   n_tog = 0, tog_cyc = 0;
   int   n_cmp = 0, n_err = 0;
   bit   rdy_en = 1'b1;
   int   rdy_lat = 8;
   int   manual_req = 0;

   function automatic logic [31:0] data_for(input logic [AW-1:0] a);
      return (a == 22'h00100) ? 32'hDEADBEEF : {10'h2A5, a};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // data_ok monitor
   initial forever begin
      obs_t o;
      @(negedge clk);
      if (!rst && data_ok != '0) begin
         o.idx = -1;
         for (int i = 0; i < N; i++) if (data_ok[i]) o.idx = i;
         o.data   = dout;
         o.cyc    = cyc;
         o.onehot = $onehot(data_ok);
         obs.push_back(o);
      end
   end

   // sdram_re toggle monitor
   initial begin
      logic re_prev;
      re_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && sdram_re !== re_prev) begin
            n_tog++;
            tog_cyc = cyc;
         end
         re_prev = sdram_re;
      end
   end

   // SDRAM controller model: rdy pulse rdy_lat cycles after each toggle, or on demand
   initial begin
      logic          m_prev;
      logic [AW-1:0] pend_a;
      int            cd, seen;
      m_prev = 1'b0; pend_a = '0; cd = 0; seen = 0;
      sdram_rdy = 1'b0; data_read = '0;
      forever begin
         @(negedge clk);
         sdram_rdy = 1'b0;
         if (rst) begin
            cd = 0;
         end else begin
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  sdram_rdy = 1'b1;
                  data_read = data_for(pend_a);
               end
            end
            if (sdram_re !== m_prev && rdy_en) begin
               cd     = rdy_lat;
               pend_a = sdram_addr;
            end
         end
         if (manual_req != seen) begin
            seen      = manual_req;
            sdram_rdy = 1'b1;
            data_read = 32'h12345678;
         end
         m_prev = sdram_re;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_cmp++;
      assert (got === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
      end
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      addr[i*AW +: AW] = a;
   endtask

   task automatic push_exp(input int i, input logic [31:0] d);
      exp_t e;
      e.idx = i; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack(input int i, input int budget, input string tag);
      bit seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge clk);
         if (data_ok[i]) begin
            seen   = 1'b1;
            req[i] = 1'b0;
         end
      end
      check({tag, " ack seen"}, 64'(seen), 64'd1);
   endtask

   task automatic wait_tog(input int target, input int budget, input string tag);
      for (int c = 0; c < budget && n_tog < target; c++) @(negedge clk);
      check({tag, " toggles"}, 64'(n_tog), 64'(target));
   endtask

   task automatic drain(input string tag);
      exp_t e;
      obs_t o;
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd >= obs.size()) begin
            check({tag, " missing ack"}, 64'(obs.size()), 64'(rd + 1));
         end else begin
            o = obs[rd];
            rd++;
            check({tag, " idx"}, 64'(o.idx), 64'(e.idx));
            check({tag, " dout"}, 64'(o.data), 64'(e.data));
            check({tag, " onehot"}, 64'(o.onehot), 64'd1);
         end
      end
      check({tag, " no extra ack"}, 64'(obs.size()), 64'(rd));
   endtask

   initial begin
      int c0, snap, t0, t_err, got;
      rst = 1'b1; downloading = 1'b0; req = '0; addr = '0;
      repeat (2) @(negedge clk);
      check("reset data_ok", 64'(data_ok), 64'd0);
      check("reset dout", 64'(dout), 64'd0);
      check("reset sdram_re", 64'(sdram_re), 64'd0);
      check("reset sdram_addr", 64'(sdram_addr), 64'd0);
      check("reset timeout_err", 64'(timeout_err), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single miss
      snap = n_tog; rdy_lat = 8;
      set_addr(0, 22'h00100); req[0] = 1'b1; c0 = cyc;
      push_exp(0, 32'hDEADBEEF);
      wait_ack(0, 40, "miss");
      #1;
      check("miss toggle count", 64'(n_tog - snap), 64'd1);
      check("miss sample->toggle", 64'(tog_cyc - c0), 64'd2);
      check("miss sdram_addr", 64'(sdram_addr), 64'h00100);
      check("miss rdy->data_ok", 64'(obs[obs.size()-1].cyc - tog_cyc), 64'd9);
      drain("miss");
      @(negedge clk);

      // cache hit, then address change forces a miss
      snap = n_tog;
      req[0] = 1'b1; c0 = cyc;
      push_exp(0, 32'hDEADBEEF);
      wait_ack(0, 10, "hit");
      #1;
      check("hit latency", 64'(obs[obs.size()-1].cyc - c0), 64'd1);
      drain("hit");
      repeat (2) @(negedge clk);
      check("hit no toggle", 64'(n_tog - snap), 64'd0);
      set_addr(0, 22'h00101); req[0] = 1'b1;
      push_exp(0, data_for(22'h00101));
      wait_ack(0, 40, "addr change");
      drain("addr change");
      check("addr change toggle", 64'(n_tog - snap), 64'd1);
      @(negedge clk);

      // round robin with all requesters held
      snap = n_tog; rdy_lat = 3;
      for (int i = 0; i < N; i++) set_addr(i, 22'h01000 + 22'(i));
      for (int r = 0; r < 2; r++)
         for (int i = 1; i <= N; i++) push_exp(i % N, data_for(22'h01000 + 22'(i % N)));
      req = '1; got = 0;
      for (int c = 0; c < 400 && got < 2*N; c++) begin
         @(negedge clk);
         if (data_ok != '0) got++;
         if (got == 2*N) req = '0;
      end
      check("rr ack count", 64'(got), 64'(2*N));
      drain("rr");
      check("rr toggles", 64'(n_tog - snap), 64'(N));
      @(negedge clk);

      // timeout, then automatic re-issue completed by a manual rdy
      snap = n_tog; rdy_en = 1'b0;
      set_addr(2, 22'h02000); req[2] = 1'b1;
      wait_tog(snap + 1, 10, "timeout first");
      t0 = tog_cyc;
      t_err = -1;
      for (int c = 0; c < 120 && t_err < 0; c++) begin
         @(negedge clk);
         if (timeout_err) t_err = cyc;
      end
      check("timeout latency", 64'(t_err - t0), 64'd63);
      wait_tog(snap + 2, 10, "timeout reissue");
      check("reissue latency", 64'(tog_cyc - t0), 64'd65);
      #1;
      check("timeout no ack", 64'(obs.size()), 64'(rd));
      push_exp(2, 32'h12345678);
      manual_req++;
      wait_ack(2, 10, "after timeout");
      drain("after timeout");
      check("timeout sticky", 64'(timeout_err), 64'd1);
      @(negedge clk);

      // downloading raised during a read
      rdy_en = 1'b1; rdy_lat = 8; snap = n_tog;
      req[1] = 1'b1;
      push_exp(1, data_for(22'h01001));
      wait_ack(1, 10, "pre-dl hit");
      drain("pre-dl hit");
      check("pre-dl hit no toggle", 64'(n_tog - snap), 64'd0);
      set_addr(3, 22'h03000); req[3] = 1'b1;
      wait_tog(snap + 1, 10, "dl read");
      repeat (2) @(negedge clk);
      downloading = 1'b1; req[1] = 1'b1;
      push_exp(3, data_for(22'h03000));
      wait_ack(3, 20, "dl read");
      repeat (6) @(negedge clk);
      drain("dl read");
      check("dl no new toggle", 64'(n_tog - snap), 64'd1);
      downloading = 1'b0;
      push_exp(1, data_for(22'h01001));
      wait_ack(1, 30, "post-dl");
      drain("post-dl");
      check("post-dl miss toggle", 64'(n_tog - snap), 64'd2);
      @(negedge clk);

      // reset while waiting, late rdy must be ignored
      rdy_en = 1'b0; snap = n_tog;
      set_addr(4, 22'h04000); req[4] = 1'b1;
      wait_tog(snap + 1, 10, "rst read");
      repeat (3) @(negedge clk);
      rst = 1'b1; req = '0;
      @(negedge clk);
      rst = 1'b0;
      manual_req++;
      repeat (4) @(negedge clk);
      #1;
      check("rst no ack", 64'(obs.size()), 64'(rd));
      check("rst data_ok", 64'(data_ok), 64'd0);
      check("rst sdram_re", 64'(sdram_re), 64'd0);
      check("rst sdram_addr", 64'(sdram_addr), 64'd0);
      check("rst dout", 64'(dout), 64'd0);
      check("rst timeout_err", 64'(timeout_err), 64'd0);
      @(negedge clk);

      // after reset the cache is empty and the FSM serves a fresh miss
      rdy_en = 1'b1; rdy_lat = 8; snap = n_tog;
      set_addr(0, 22'h00100); req[0] = 1'b1;
      push_exp(0, 32'hDEADBEEF);
      wait_ack(0, 40, "post-rst");
      drain("post-rst");
      check("post-rst toggle", 64'(n_tog - snap), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
